// File: rtl/edge_pulse_counter.sv
// Synchronizes and debounces a slow single-bit level, emits one-cycle rise/fall
// pulses and counts the selected edge type in a saturating counter with sticky overflow.
module edge_pulse_counter #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int CNT_W       = 8,
  parameter     EDGE_SEL    = "RISE"
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             din,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  localparam int              STAB_W    = $clog2(DEBOUNCE) + 1;
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEBOUNCE - 1);
  localparam bit              CNT_RISE  = (EDGE_SEL == "RISE") || (EDGE_SEL == "BOTH");
  localparam bit              CNT_FALL  = (EDGE_SEL == "FALL") || (EDGE_SEL == "BOTH");

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   sync_out;
  logic [STAB_W-1:0]      stab_cnt, stab_nxt;
  logic                   level_nxt, rise_nxt, fall_nxt;
  logic                   edge_evt;
  logic [CNT_W-1:0]       count_nxt;
  logic                   ovf_nxt;

  // Stage p0: synchronizer chain, din enters at bit 0
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
    end else begin
      sync_p0[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_p0[i] <= sync_p0[i-1];
      end
    end
  end

  assign sync_out = sync_p0[SYNC_STAGES-1];

  // Stage p1: stability filter and counter next-state; the edge event is taken
  // from the flip decision so count moves on the same edge the pulse appears.
  always_comb begin
    stab_nxt  = '0;
    level_nxt = level;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    if (sync_out != level) begin
      if (stab_cnt == STAB_LAST) begin
        level_nxt = sync_out;
        rise_nxt  = sync_out;
        fall_nxt  = !sync_out;
      end else begin
        stab_nxt = stab_cnt + 1'b1;
      end
    end

    edge_evt  = (rise_nxt & CNT_RISE) | (fall_nxt & CNT_FALL);
    count_nxt = count;
    ovf_nxt   = ovf;
    if (clr) begin
      count_nxt = '0;
      ovf_nxt   = 1'b0;
    end else if (en && edge_evt) begin
      if (count == {CNT_W{1'b1}}) begin
        ovf_nxt = 1'b1;
      end else begin
        count_nxt = count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stab_cnt <= '0;
      level    <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
      count    <= '0;
      ovf      <= 1'b0;
    end else begin
      stab_cnt <= stab_nxt;
      level    <= level_nxt;
      rise     <= rise_nxt;
      fall     <= fall_nxt;
      count    <= count_nxt;
      ovf      <= ovf_nxt;
    end
  end

endmodule

// File: doc/edge_pulse_counter.md
Name: edge_pulse_counter

Overview:
- Downstream consumer of the D/T flip-flop stage. Takes that stage's single-bit `q` output (or any slow/asynchronous level) and passes it through an N-stage synchronizer.
- Debounces the synchronized level with a stability filter, then emits one-cycle rise/fall pulses.
- Counts the selected edge type in a saturating counter with a sticky overflow flag.
- Used to check and measure toggle activity of the flip-flop stage in-system.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops (≥1).
- DEBOUNCE, 4, consecutive cycles the synchronized input must differ from `level` before `level` flips (≥1).
- CNT_W, 8, edge counter width.
- EDGE_SEL, "RISE", edge counted: "RISE", "FALL" or "BOTH"; any other value counts nothing.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; gates counter only.
- clr  input  1  synchronous clear of `count` and `ovf`.
- din  input  1  raw input level (the flip-flop stage's `q`).
- level  output  1  debounced level.
- rise  output  1  one-cycle pulse, `level` went 0→1.
- fall  output  1  one-cycle pulse, `level` went 1→0.
- count  output  CNT_W  saturating count of selected edges.
- ovf  output  1  sticky; an edge was dropped at saturation.

Behaviour:
- Reset: clk is the only clock; rst is synchronous and active-high. While rst=1 at a clk edge, the following load 0: all sync flops, `stab_cnt`, `level`, `rise`, `fall`, `count`, `ovf`. rst overrides every other input. Reset mid-debounce discards the partial `stab_cnt`.
- Synchronizer: shift chain `din`→s[0]→…→s[SYNC_STAGES-1]. `sync_out` = last stage. No reset-time metastability handling beyond the chain itself.
- Debounce (`stab_cnt` width = clog2(DEBOUNCE)+1), evaluated each edge using current `sync_out`:
  - If `sync_out == level`: `stab_cnt` <= 0.
  - Else if `stab_cnt == DEBOUNCE-1`: `level` <= `sync_out`, `stab_cnt` <= 0, and `rise` <= `sync_out` and `fall` <= !`sync_out`.
  - Else: `stab_cnt` <= `stab_cnt`+1.
  - `rise`/`fall` are 0 on every edge not taking the flip branch. They are registered, high exactly one cycle, coincident with the new `level`.
  - Pulses on consecutive flips are never merged or stretched.
- Latency: a `din` change first sampled at edge k appears on `level` (and pulse) after edge k+SYNC_STAGES+DEBOUNCE-1. With the defaults, that is the 6th edge, inclusive of edge k.
- Glitch rule: `sync_out` deviations lasting fewer than DEBOUNCE cycles never change `level` and produce no pulse.
- Counter: event = (`rise` & EDGE_SEL∈{RISE,BOTH}) | (`fall` & EDGE_SEL∈{FALL,BOTH}), computed from the same-edge flip condition. `count` updates on the same edge as the pulse.
- Counter priority per edge: rst > clr > (en & event).
  - clr=1: `count` <= 0, `ovf` <= 0. A simultaneous event is dropped and does not set `ovf`.
  - en & event & `count` < 2^CNT_W−1: `count` <= `count`+1.
  - en & event & `count` == 2^CNT_W−1: `count` holds at max, `ovf` <= 1.
  - en=0: `count`/`ovf` hold. Filter, `level` and pulses still run.
- `ovf` stays 1 until clr or rst. No wrap-around of `count`, ever.
- Filter and counter state machine is implicit: IDLE (equal, `stab_cnt`=0) / QUALIFY (differs, counting) / FLIP (one-cycle pulse); no other states.

Test Plan:
- Defaults, rst 2 cycles, then din 0→1 before edge 0, en=1 → `level`=1 and `rise`=1 for one cycle after edge 5; `count`=1; `fall`=0 throughout.
- din high for exactly 3 cycles then low → no `level` change, no pulse, `count` stays 0. Repeat with 4 cycles → `rise` after edge 5 and `fall` 4 cycles later; `count`=1 (RISE).
- EDGE_SEL="BOTH", CNT_W=3, 10 clean toggles (each held 8 cycles) → `count` saturates at 7. `ovf`=1 from the 8th edge. Then clr=1 one cycle → `count`=0, `ovf`=0.
- clr asserted on the same edge as a `rise` → `count`=0 afterwards, `ovf` unchanged at 0. en=0 during 3 rises → `count` unchanged, `rise` pulses still seen.
- rst asserted at `stab_cnt`=2 during a qualifying high → `level`, `count`, `ovf` = 0 next cycle. After rst release, with din still 1, a `rise` appears exactly 6 edges later.
- Drive din from the flip-flop stage's `q`, with its `d` randomized for 100 cycles → `count` equals the number of its 0→1 transitions that persisted ≥4 cycles (scoreboard model).
